// File: rtl/melody_matcher.sv
// melody_matcher: debounces the note recognizer's report stream into
// accepted note events, tracks progress through a parameter-programmed
// melody and flags a complete match (and the resulting "unlocked" level).
//
// Optional build macro: MELODY_MATCHER_TIMEOUT_EN
//   Defined   : an inactivity counter abandons partial progress after
//               timeout_ms milliseconds without an accepted note.
//   Undefined : no counter; progress persists indefinitely.

module melody_matcher #(
    parameter int unsigned clk_mhz    = 50,
    parameter int unsigned melody_len = 4,
    parameter logic [31:0] melody     = 32'h0000_B740,
    parameter int unsigned stable_cnt = 4,
    parameter int unsigned timeout_ms = 2000
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            note_vld,
    input  logic [3:0]                      note_idx,
    output logic                            acc_vld,
    output logic [3:0]                      acc_idx,
    output logic [$clog2(melody_len+1)-1:0] progress,
    output logic                            match,
    output logic                            unlocked
);

    localparam int unsigned PW        = $clog2(melody_len + 1);
    localparam logic [3:0]  NO_NOTE   = 4'hF;
    localparam logic [3:0]  SCNT_MAX  = 4'd15;
    localparam logic [3:0]  FIRST_IDX = 4'd12;

    // Reject parameter values outside the supported ranges at elaboration.
    if (melody_len < 1 || melody_len > 8) begin : g_bad_len
        $error("melody_matcher: melody_len must be 1..8");
    end
    if (stable_cnt < 1 || stable_cnt > 15) begin : g_bad_stable
        $error("melody_matcher: stable_cnt must be 1..15");
    end
    if (clk_mhz < 1 || timeout_ms < 1) begin : g_bad_timeout
        $error("melody_matcher: clk_mhz and timeout_ms must be non-zero");
    end

    logic [3:0] cand;
    logic [3:0] scnt;
    logic [3:0] last;

    logic       no_note_c;
    logic [3:0] scnt_upd_c;
    logic       accept_c;
    logic [3:0] mel_note_c;
    logic       hit_c;
    logic       is_last_c;
    logic       first_hit_c;
    logic       tmo_fire_c;

    // Debounce decision for the current report: updated stability count and accept.
    always_comb begin
        no_note_c  = 1'b0;
        scnt_upd_c = 4'd1;
        accept_c   = 1'b0;
        no_note_c  = (note_idx >= FIRST_IDX);
        if (note_idx == cand) begin
            scnt_upd_c = (scnt == SCNT_MAX) ? SCNT_MAX : scnt + 4'd1;
        end
        accept_c = note_vld && !no_note_c
                   && (scnt_upd_c == 4'(stable_cnt))
                   && (note_idx != last);
    end

    // Debounce state and the accepted-note outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cand    <= NO_NOTE;
            scnt    <= 4'd0;
            last    <= NO_NOTE;
            acc_vld <= 1'b0;
            acc_idx <= NO_NOTE;
        end else begin
            acc_vld <= accept_c;
            if (accept_c) begin
                acc_idx <= note_idx;
            end
            if (note_vld) begin
                if (no_note_c) begin
                    cand <= NO_NOTE;
                    scnt <= 4'd0;
                end else begin
                    cand <= note_idx;
                    scnt <= scnt_upd_c;
                end
            end
            // Silence re-arms a repeated note; an abandoned attempt does too.
            if (note_vld && no_note_c) begin
                last <= NO_NOTE;
            end else if (accept_c) begin
                last <= note_idx;
            end else if (tmo_fire_c) begin
                last <= NO_NOTE;
            end
        end
    end

    // Compare the accepted note against the expected melody note at progress p.
    always_comb begin
        mel_note_c  = 4'd0;
        hit_c       = 1'b0;
        is_last_c   = 1'b0;
        first_hit_c = 1'b0;
        mel_note_c  = melody[4 * int'(progress) +: 4];
        hit_c       = (acc_idx == mel_note_c);
        is_last_c   = (progress == PW'(melody_len - 1));
        first_hit_c = (acc_idx == melody[3:0]);
    end

    // Melody progress, match pulse and unlocked level.
    always_ff @(posedge clk) begin
        if (rst) begin
            progress <= '0;
            match    <= 1'b0;
            unlocked <= 1'b0;
        end else begin
            match <= 1'b0;
            if (acc_vld) begin
                if (hit_c && is_last_c) begin
                    match    <= 1'b1;
                    progress <= '0;
                    unlocked <= 1'b1;
                end else if (hit_c) begin
                    progress <= progress + PW'(1);
                    unlocked <= 1'b0;
                end else if (first_hit_c) begin
                    // A one-note melody never lands here: its hit case covers note 0.
                    progress <= PW'(1);
                    unlocked <= 1'b0;
                end else begin
                    progress <= '0;
                    unlocked <= 1'b0;
                end
            end else if (tmo_fire_c) begin
                progress <= '0;
            end
        end
    end

`ifdef MELODY_MATCHER_TIMEOUT_EN
    localparam int unsigned TMO_CYCLES = clk_mhz * 1000 * timeout_ms;
    localparam int unsigned TW         = (TMO_CYCLES > 1) ? $clog2(TMO_CYCLES) : 1;
    localparam logic [TW-1:0] TMO_LIMIT = TW'(TMO_CYCLES - 1);

    logic [TW-1:0] tmo_cnt;

    // Inactivity counter: restarts on every accepted note, saturates at the limit.
    always_ff @(posedge clk) begin
        if (rst || acc_vld) begin
            tmo_cnt <= '0;
        end else if (tmo_cnt != TMO_LIMIT) begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    // An accepted note in the same cycle takes priority over the timeout.
    assign tmo_fire_c = (tmo_cnt == TMO_LIMIT) && (progress != '0) && !acc_vld;
`else
    assign tmo_fire_c = 1'b0;
`endif

endmodule

// File: tb/tb_melody_matcher.sv
// Self-checking bench for melody_matcher: a per-cycle vector table for the
// main debounce/match behaviour, then hand-written multi-cycle sequences.
// Melody under test: 0, 4, 7, 11 (32'h0000_B740), stable_cnt = 4.

module tb_melody_matcher;

`ifdef MELODY_MATCHER_TIMEOUT_EN
    localparam int unsigned TB_MHZ = 1;
    localparam int unsigned TB_MS  = 1;
`else
    localparam int unsigned TB_MHZ = 50;
    localparam int unsigned TB_MS  = 2000;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       note_vld = 1'b0;
    logic [3:0] note_idx = 4'd0;
    logic       acc_vld;
    logic [3:0] acc_idx;
    logic [2:0] progress;
    logic       match;
    logic       unlocked;

    int checks = 0;
    int errors = 0;

    melody_matcher #(
        .clk_mhz    (TB_MHZ),
        .melody_len (4),
        .melody     (32'h0000_B740),
        .stable_cnt (4),
        .timeout_ms (TB_MS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .note_vld (note_vld),
        .note_idx (note_idx),
        .acc_vld  (acc_vld),
        .acc_idx  (acc_idx),
        .progress (progress),
        .match    (match),
        .unlocked (unlocked)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       vld;
        logic [3:0] idx;
        logic       e_acc;
        logic [3:0] e_aidx;
        logic [2:0] e_prog;
        logic       e_match;
        logic       e_unl;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Apply one cycle of input, then sample just after the edge.
    task automatic step(input logic v, input logic [3:0] i);
        note_vld = v;
        note_idx = i;
        @(posedge clk);
        #1;
        note_vld = 1'b0;
    endtask

    // Four reports of a note (expected to be accepted) plus one idle cycle.
    task automatic send(input logic [3:0] i);
        for (int k = 0; k < 4; k++) step(1'b1, i);
        chk("send_acc_vld", 32'(acc_vld), 1);
        chk("send_acc_idx", 32'(acc_idx), 32'(i));
        step(1'b0, 4'd0);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_acc_vld"}, 32'(acc_vld), 0);
        chk({nm, "_acc_idx"}, 32'(acc_idx), 32'hF);
        chk({nm, "_progress"}, 32'(progress), 0);
        chk({nm, "_match"}, 32'(match), 0);
        chk({nm, "_unlocked"}, 32'(unlocked), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        // {vld, idx, acc_vld, acc_idx, progress, match, unlocked} after each edge
        vecs.push_back('{1, 0,  0, 4'hF, 0, 0, 0});
        vecs.push_back('{1, 0,  0, 4'hF, 0, 0, 0});
        vecs.push_back('{1, 0,  0, 4'hF, 0, 0, 0});
        vecs.push_back('{1, 0,  1, 4'h0, 0, 0, 0});  // 4th report of 0 accepted
        vecs.push_back('{1, 0,  0, 4'h0, 1, 0, 0});  // 5th report ignored, progress 1
        vecs.push_back('{0, 0,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 7,  0, 4'h0, 1, 0, 0});  // 4 x3 then 7: nothing accepted
        vecs.push_back('{0, 0,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  0, 4'h0, 1, 0, 0});
        vecs.push_back('{1, 4,  1, 4'h4, 1, 0, 0});
        vecs.push_back('{1, 7,  0, 4'h4, 2, 0, 0});
        vecs.push_back('{1, 7,  0, 4'h4, 2, 0, 0});
        vecs.push_back('{1, 7,  0, 4'h4, 2, 0, 0});
        vecs.push_back('{1, 7,  1, 4'h7, 2, 0, 0});
        vecs.push_back('{1, 11, 0, 4'h7, 3, 0, 0});
        vecs.push_back('{1, 11, 0, 4'h7, 3, 0, 0});
        vecs.push_back('{1, 11, 0, 4'h7, 3, 0, 0});
        vecs.push_back('{1, 11, 1, 4'hB, 3, 0, 0});
        vecs.push_back('{0, 0,  0, 4'hB, 0, 1, 1});  // match two cycles after 4th 11
        vecs.push_back('{0, 0,  0, 4'hB, 0, 0, 1});
        vecs.push_back('{1, 4,  0, 4'hB, 0, 0, 1});
        vecs.push_back('{1, 4,  0, 4'hB, 0, 0, 1});
        vecs.push_back('{1, 4,  0, 4'hB, 0, 0, 1});
        vecs.push_back('{1, 4,  1, 4'h4, 0, 0, 1});
        vecs.push_back('{0, 0,  0, 4'h4, 0, 0, 0});  // accepted 4 clears unlocked

        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].vld, vecs[i].idx);
            chk($sformatf("v%0d_acc_vld", i), 32'(acc_vld), 32'(vecs[i].e_acc));
            chk($sformatf("v%0d_acc_idx", i), 32'(acc_idx), 32'(vecs[i].e_aidx));
            chk($sformatf("v%0d_progress", i), 32'(progress), 32'(vecs[i].e_prog));
            chk($sformatf("v%0d_match", i), 32'(match), 32'(vecs[i].e_match));
            chk($sformatf("v%0d_unlocked", i), 32'(unlocked), 32'(vecs[i].e_unl));
            if (i == 9) begin
                chk("cand_after_4447", 32'(dut.cand), 7);
                chk("scnt_after_4447", 32'(dut.scnt), 1);
            end
        end

        // 0, 4, 9: progress 1, 2, 0
        send(4'd0);  chk("p049_a", 32'(progress), 1);
        send(4'd4);  chk("p049_b", 32'(progress), 2);
        send(4'd9);  chk("p049_c", 32'(progress), 0);

        // 0, (15), 0, 4: silence re-arms note 0, progress 1, 1, 2
        send(4'd0);  chk("rearm_a", 32'(progress), 1);
        step(1'b1, 4'd15);
        send(4'd0);  chk("rearm_b", 32'(progress), 1);
        send(4'd4);  chk("rearm_c", 32'(progress), 2);

        // Reach progress 3, reset for one cycle, then 11 alone makes no progress
        send(4'd7);  chk("pre_rst_prog", 32'(progress), 3);
        do_reset();
        chk_reset_outputs("midrst");
        send(4'd11); chk("post_rst_prog", 32'(progress), 0);

`ifdef MELODY_MATCHER_TIMEOUT_EN
        // Idle timeout abandons progress after 1000 cycles
        do_reset();
        send(4'd0);
        send(4'd4);
        chk("tmo_start", 32'(progress), 2);
        repeat (990) @(posedge clk);
        #1;
        chk("tmo_before", 32'(progress), 2);
        repeat (20) @(posedge clk);
        #1;
        chk("tmo_after", 32'(progress), 0);

        // Accepted note landing on the limit cycle wins over the timeout
        do_reset();
        send(4'd0);
        send(4'd4);
        repeat (995) @(posedge clk);
        #1;
        chk("tmo_race_before", 32'(progress), 2);
        for (int k = 0; k < 4; k++) step(1'b1, 4'd7);
        chk("tmo_race_acc", 32'(acc_vld), 1);
        step(1'b0, 4'd0);
        chk("tmo_race_prog", 32'(progress), 3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/melody_matcher.md
# melody_matcher

Downstream consumer of the note recognizer's `note_vld`/`note_idx` report stream.
- Debounces the report stream into accepted note events.
- Tracks progress through a parameter-programmed melody and flags a complete match.
- Its outputs drive LED/graphics indications of melody progress and an "unlocked" state.

## Interface
- `clk_mhz`, 50, clock frequency in MHz; sizes the timeout counter.
- `melody_len`, 4, number of notes in the melody, 1..8.
- `melody`, 32'h0000_B740, packed 4-bit note indices; note 0 of the melody in bits [3:0]; only the low `melody_len*4` bits are used.
- `stable_cnt`, 4, consecutive identical valid reports needed to accept a note, 1..15.
- `timeout_ms`, 2000, inactivity window before progress is abandoned; used only with the timeout feature.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `note_vld`  in  1  single-cycle report strobe from the recognizer.
- `note_idx`  in  4  reported note; 0..11 valid; 12..15 mean "no note".
- `acc_vld`  out  1  one-cycle pulse: a note was accepted.
- `acc_idx`  out  4  last accepted note; held between pulses.
- `progress`  out  `$clog2(melody_len+1)`  melody notes matched so far.
- `match`  out  1  one-cycle pulse on melody completion.
- `unlocked`  out  1  level; set by `match`, cleared by the next `acc_vld`.

## Operation
Internal registers:
- `cand`, 4 bits, reset 4'hF: candidate note.
- `scnt`, 4 bits, reset 0: stability count.
- `last`, 4 bits, reset 4'hF: last accepted note.

Debounce stage acts only on cycles where `note_vld` = 1:
- `note_idx` ≥ 12: `cand`←F, `scnt`←0, `last`←F. A repeated note after silence therefore counts again.
- `note_idx` = `cand`: `scnt` increments, saturating at 15.
- Otherwise: `cand`←`note_idx`, `scnt`←1.
- Accept when the updated `scnt` equals exactly `stable_cnt` and `note_idx` ≠ `last`.
- On accept: `acc_vld` pulses, `acc_idx`←`note_idx`, `last`←`note_idx`.
- Further identical reports never re-accept.

Match stage acts on `acc_vld`, with p = `progress`:
- `acc_idx` = `melody[p]`: if p = `melody_len-1` then `match` pulses, `progress`←0 and `unlocked`←1; else `progress`←p+1.
- Else if `acc_idx` = `melody[0]`: `progress`←1. If `melody_len` = 1, this is a match instead.
- Else: `progress`←0.
- Any `acc_vld` that is not itself a match clears `unlocked`.

Reset values: `acc_vld` 0, `acc_idx` F, `progress` 0, `match` 0, `unlocked` 0. Reset mid-sequence discards all progress and takes effect on the next edge.

## Timing
- Report at cycle T (accepting): `acc_vld`/`acc_idx` at T+1.
- `progress`/`match`/`unlocked` update at T+2.
- Back-to-back `note_vld` every cycle is supported. The pipeline accepts at most one note per cycle, with no stalls and no backpressure.
- `note_idx` is ignored when `note_vld` = 0.
- Registers are widened to avoid overflow. `melody[p]` indexing is never out of range because p < `melody_len`.

## Configuration
`MELODY_MATCHER_TIMEOUT_EN`

Defined:
- Counter width is `$clog2(clk_mhz*1000*timeout_ms)`, compared against `clk_mhz*1000*timeout_ms-1`.
- The counter clears on every `acc_vld` and on reset, and otherwise increments, saturating at the limit.
- When the counter reaches the limit with `progress` ≠ 0: `progress`←0 and `last`←F, one cycle later.
- If an accepted note arrives in the same cycle, the note has priority and the timeout is ignored.
- `unlocked` is unaffected by the timeout.

Undefined:
- No counter is built; progress persists indefinitely.

## Test plan
- Reset, then 4 reports of idx 0 on consecutive cycles: one `acc_vld` with `acc_idx`=0 one cycle after the 4th report; `progress`=1; no `acc_vld` on a 5th report of 0.
- Note 4 reported 3 times, then 7 once: nothing accepted; `cand`=7 with `scnt`=1.
- Sequence 0,4,7,11, each reported 4 times: `match` pulses once, two cycles after the 4th report of 11; `progress`=0; `unlocked`=1; a following accepted 4 clears `unlocked`.
- Sequence 0,4,9: `progress` goes 1, 2, 0. Then sequence 0,0-after-idx-15, 4: the report of 15 re-arms note 0, so `progress` goes 1, 1, 2.
- Assert `rst` one cycle with `progress`=3: all outputs return to reset values next cycle; then 4 reports of 11 give `progress`=0.
- With the macro defined, `clk_mhz`=1, `timeout_ms`=1: `progress`=2, idle 1000 cycles → `progress`=0; re-run with an accepted note landing on the limit cycle → `progress` advances normally.
